// File: rtl/uart_sram_loader_if.sv
// Bundles the byte-stream input from the UART receiver, the SRAM write port
// and the status outputs of uart_sram_loader.
//   master : loader side (consumes rx_*, mem_gnt; drives SRAM port and status)
//   slave  : environment side (UART receiver, bus arbiter, SRAM, CPU)
interface uart_sram_loader_if #(
  parameter int AW = 16
);
  logic [7:0]    rx_dat;
  logic          rx_stb;
  logic          rx_err;
  logic          mem_req;
  logic          mem_gnt;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdat;
  logic          mem_we;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    input  rx_dat, rx_stb, rx_err, mem_gnt,
    output mem_req, mem_addr, mem_wdat, mem_we, cpu_hold, busy, done, err
  );

  modport slave (
    output rx_dat, rx_stb, rx_err, mem_gnt,
    input  mem_req, mem_addr, mem_wdat, mem_we, cpu_hold, busy, done, err
  );
endinterface

// File: rtl/uart_sram_loader.sv
// uart_sram_loader
// Parses framed load commands from the UART byte stream
//   SYNC, ADDR_H, ADDR_L, LEN (0 = 256), payload[LEN] (, checksum)
// and writes the payload to consecutive SRAM addresses through a req/gnt
// handshake, holding the CPU off the bus while a frame is in flight.
// Optional feature macro: CHECKSUM_EN -- adds a trailing XOR checksum byte
// over ADDR_H, ADDR_L, LEN and the payload, checked in a CHK state.
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   bus    : uart_sram_loader_if.master
//            rx_dat/rx_stb/rx_err  byte input and framing-error pulse
//            mem_req/mem_gnt       SRAM arbitration handshake
//            mem_addr/mem_wdat     write address/data, stable while mem_req=1
//            mem_we                mem_req & mem_gnt
//            cpu_hold/busy         frame in flight / FSM not idle
//            done/err              completion pulse / sticky error flag
module uart_sram_loader #(
  parameter int         AW   = 16,
  parameter logic [7:0] SYNC = 8'h55
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_sram_loader_if.master    bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR_H, ADDR_L, LEN, DATA, WRITE
`ifdef CHECKSUM_EN
    , CHK
`endif
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] mem_addr, addr_n;
  logic [7:0]    mem_wdat, wdat_n;
  logic          mem_req, req_n;
  logic          cpu_hold, hold_n;
  logic          done, done_n;
  logic          err, err_n;
  logic [8:0]    cnt, cnt_n;
  logic          abort;
`ifdef CHECKSUM_EN
  logic [7:0]    csum, csum_n;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    addr_n  = mem_addr;
    wdat_n  = mem_wdat;
    req_n   = mem_req;
    hold_n  = cpu_hold;
    err_n   = err;
    done_n  = 1'b0;
    cnt_n   = cnt;
    abort   = 1'b0;
`ifdef CHECKSUM_EN
    csum_n  = csum;
`endif
    case (state)
      IDLE: begin
        if (bus.rx_stb && bus.rx_dat == SYNC) begin
          state_n = ADDR_H;
          hold_n  = 1'b1;
          err_n   = 1'b0;
`ifdef CHECKSUM_EN
          csum_n  = 8'h00;
`endif
        end
      end
      ADDR_H: begin
        if (bus.rx_stb) begin
          // Cast drops address bits above AW when AW < 16.
          addr_n  = AW'({bus.rx_dat, mem_addr[7:0]});
          state_n = ADDR_L;
`ifdef CHECKSUM_EN
          csum_n  = csum ^ bus.rx_dat;
`endif
        end
      end
      ADDR_L: begin
        if (bus.rx_stb) begin
          addr_n[7:0] = bus.rx_dat;
          state_n     = LEN;
`ifdef CHECKSUM_EN
          csum_n      = csum ^ bus.rx_dat;
`endif
        end
      end
      LEN: begin
        if (bus.rx_stb) begin
          cnt_n   = (bus.rx_dat == 8'h00) ? 9'd256 : {1'b0, bus.rx_dat};
          state_n = DATA;
`ifdef CHECKSUM_EN
          csum_n  = csum ^ bus.rx_dat;
`endif
        end
      end
      DATA: begin
        if (bus.rx_stb) begin
          wdat_n  = bus.rx_dat;
          req_n   = 1'b1;
          state_n = WRITE;
`ifdef CHECKSUM_EN
          csum_n  = csum ^ bus.rx_dat;
`endif
        end
      end
      WRITE: begin
        if (bus.mem_gnt) begin
          req_n  = 1'b0;
          addr_n = mem_addr + AW'(1);
          cnt_n  = cnt - 9'd1;
          if (cnt == 9'd1) begin
`ifdef CHECKSUM_EN
            state_n = CHK;
`else
            state_n = IDLE;
            done_n  = 1'b1;
            hold_n  = 1'b0;
`endif
          end else begin
            state_n = DATA;
          end
        end
        // A new byte before the write finished is an overrun. If the grant
        // arrives in the same cycle the write still happens (mem_we is
        // combinational), the frame is aborted afterwards.
        if (bus.rx_stb) abort = 1'b1;
      end
`ifdef CHECKSUM_EN
      CHK: begin
        if (bus.rx_stb) begin
          state_n = IDLE;
          hold_n  = 1'b0;
          if (bus.rx_dat == csum) done_n = 1'b1;
          else                    err_n  = 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase

    if (bus.rx_err && state != IDLE) abort = 1'b1;

    if (abort) begin
      state_n = IDLE;
      req_n   = 1'b0;
      hold_n  = 1'b0;
      err_n   = 1'b1;
      done_n  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr <= '0;
      mem_wdat <= '0;
      mem_req  <= 1'b0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cnt      <= '0;
`ifdef CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      mem_addr <= addr_n;
      mem_wdat <= wdat_n;
      mem_req  <= req_n;
      cpu_hold <= hold_n;
      done     <= done_n;
      err      <= err_n;
      cnt      <= cnt_n;
`ifdef CHECKSUM_EN
      csum     <= csum_n;
`endif
    end
  end

  assign bus.mem_req  = mem_req;
  assign bus.mem_addr = mem_addr;
  assign bus.mem_wdat = mem_wdat;
  assign bus.mem_we   = mem_req & bus.mem_gnt;
  assign bus.cpu_hold = cpu_hold;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done;
  assign bus.err      = err;

endmodule

// File: tb/tb_uart_sram_loader.sv
// Self-checking bench for uart_sram_loader (AW=16, SYNC=8'h55).
module tb_uart_sram_loader;

  logic clk;
  logic reset;

  uart_sram_loader_if #(.AW(16)) bus();

  uart_sram_loader #(.AW(16), .SYNC(8'h55)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int we_cnt = 0;

  // Count write strobes well away from both clock edges.
  always @(negedge clk) begin
    #2;
    if (bus.mem_we === 1'b1) we_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string       name;
    logic        stb;
    logic [7:0]  dat;
    logic        rxe;
    logic        gnt;
    logic [29:0] exp;
  } vec_t;

  vec_t vecs[$];

  // {mem_req, mem_we, mem_addr, mem_wdat, cpu_hold, busy, done, err}
  function automatic logic [29:0] outs();
    return {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdat,
            bus.cpu_hold, bus.busy, bus.done, bus.err};
  endfunction

  task automatic add(input string nm, input logic stb, input logic [7:0] dat,
                     input logic rxe, input logic gnt,
                     input logic req, input logic we, input logic [15:0] addr,
                     input logic [7:0] wdat, input logic hold, input logic bsy,
                     input logic dn, input logic e);
    vec_t v;
    v.name = nm; v.stb = stb; v.dat = dat; v.rxe = rxe; v.gnt = gnt;
    v.exp  = {req, we, addr, wdat, hold, bsy, dn, e};
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 unit later.
  task automatic drive(input logic stb, input logic [7:0] dat,
                       input logic rxe, input logic gnt);
    @(negedge clk);
    bus.rx_stb  = stb;
    bus.rx_dat  = dat;
    bus.rx_err  = rxe;
    bus.mem_gnt = gnt;
    #1;
  endtask

  int          base;
  logic [15:0] ea;
  logic [7:0]  cs;

  initial begin
    reset       = 1'b1;
    bus.rx_stb  = 1'b0;
    bus.rx_dat  = 8'h00;
    bus.rx_err  = 1'b0;
    bus.mem_gnt = 1'b0;
    #12;
    chk("reset_state", {2'b0, outs()}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

`ifdef CHECKSUM_EN
    cs = 8'h12 ^ 8'h34 ^ 8'h01 ^ 8'hAA;
    for (int pass = 0; pass < 2; pass++) begin
      drive(1, 8'h55, 0, 1); drive(1, 8'h12, 0, 1); drive(1, 8'h34, 0, 1);
      drive(1, 8'h01, 0, 1); drive(1, 8'hAA, 0, 1);
      drive(0, 8'h00, 0, 1);
      chk("cs_write", {bus.mem_we, bus.mem_addr, bus.mem_wdat}, {1'b1, 16'h1234, 8'hAA});
      drive(0, 8'h00, 0, 1);
      chk("cs_wait", {bus.mem_req, bus.cpu_hold, bus.busy, bus.done}, 4'b0110);
      drive(1, (pass == 0) ? cs : 8'h00, 0, 1);
      drive(0, 8'h00, 0, 1);
      chk(pass == 0 ? "cs_good" : "cs_bad",
          {bus.cpu_hold, bus.busy, bus.done, bus.err},
          pass == 0 ? 4'b0010 : 4'b0001);
    end
`else
    // test 1: 55 12 34 02 AA BB, grant tied high
    add("t1_sync", 1, 8'h55, 0, 1, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 0);
    add("t1_ah",   1, 8'h12, 0, 1, 0, 0, 16'h0000, 8'h00, 1, 1, 0, 0);
    add("t1_al",   1, 8'h34, 0, 1, 0, 0, 16'h1200, 8'h00, 1, 1, 0, 0);
    add("t1_len",  1, 8'h02, 0, 1, 0, 0, 16'h1234, 8'h00, 1, 1, 0, 0);
    add("t1_d0",   1, 8'hAA, 0, 1, 0, 0, 16'h1234, 8'h00, 1, 1, 0, 0);
    add("t1_w0",   0, 8'h00, 0, 1, 1, 1, 16'h1234, 8'hAA, 1, 1, 0, 0);
    add("t1_d1",   1, 8'hBB, 0, 1, 0, 0, 16'h1235, 8'hAA, 1, 1, 0, 0);
    add("t1_w1",   0, 8'h00, 0, 1, 1, 1, 16'h1235, 8'hBB, 1, 1, 0, 0);
    add("t1_done", 0, 8'h00, 0, 1, 0, 0, 16'h1236, 8'hBB, 0, 0, 1, 0);
    add("t1_idle", 0, 8'h00, 0, 1, 0, 0, 16'h1236, 8'hBB, 0, 0, 0, 0);
    // test 2: address wrap FFFF -> 0000
    add("t2_sync", 1, 8'h55, 0, 1, 0, 0, 16'h1236, 8'hBB, 0, 0, 0, 0);
    add("t2_ah",   1, 8'hFF, 0, 1, 0, 0, 16'h1236, 8'hBB, 1, 1, 0, 0);
    add("t2_al",   1, 8'hFF, 0, 1, 0, 0, 16'hFF36, 8'hBB, 1, 1, 0, 0);
    add("t2_len",  1, 8'h02, 0, 1, 0, 0, 16'hFFFF, 8'hBB, 1, 1, 0, 0);
    add("t2_d0",   1, 8'h01, 0, 1, 0, 0, 16'hFFFF, 8'hBB, 1, 1, 0, 0);
    add("t2_w0",   0, 8'h00, 0, 1, 1, 1, 16'hFFFF, 8'h01, 1, 1, 0, 0);
    add("t2_d1",   1, 8'h02, 0, 1, 0, 0, 16'h0000, 8'h01, 1, 1, 0, 0);
    add("t2_w1",   0, 8'h00, 0, 1, 1, 1, 16'h0000, 8'h02, 1, 1, 0, 0);
    add("t2_done", 0, 8'h00, 0, 1, 0, 0, 16'h0001, 8'h02, 0, 0, 1, 0);
    // test 4: grant withheld, second byte overruns
    add("t4_sync", 1, 8'h55, 0, 0, 0, 0, 16'h0001, 8'h02, 0, 0, 0, 0);
    add("t4_ah",   1, 8'h00, 0, 0, 0, 0, 16'h0001, 8'h02, 1, 1, 0, 0);
    add("t4_al",   1, 8'h20, 0, 0, 0, 0, 16'h0001, 8'h02, 1, 1, 0, 0);
    add("t4_len",  1, 8'h01, 0, 0, 0, 0, 16'h0020, 8'h02, 1, 1, 0, 0);
    add("t4_d0",   1, 8'hCC, 0, 0, 0, 0, 16'h0020, 8'h02, 1, 1, 0, 0);
    add("t4_wait", 0, 8'h00, 0, 0, 1, 0, 16'h0020, 8'hCC, 1, 1, 0, 0);
    add("t4_ovr",  1, 8'h77, 0, 0, 1, 0, 16'h0020, 8'hCC, 1, 1, 0, 0);
    add("t4_abrt", 0, 8'h00, 0, 0, 0, 0, 16'h0020, 8'hCC, 0, 0, 0, 1);
    add("t4_sync2",1, 8'h55, 0, 0, 0, 0, 16'h0020, 8'hCC, 0, 0, 0, 1);
    add("t4_clr",  0, 8'h00, 0, 0, 0, 0, 16'h0020, 8'hCC, 1, 1, 0, 0);
    // test 5: rx_err during LEN, junk and rx_err ignored in IDLE
    add("t5_ah",   1, 8'h12, 0, 0, 0, 0, 16'h0020, 8'hCC, 1, 1, 0, 0);
    add("t5_al",   1, 8'h34, 0, 0, 0, 0, 16'h1220, 8'hCC, 1, 1, 0, 0);
    add("t5_rxe",  0, 8'h00, 1, 0, 0, 0, 16'h1234, 8'hCC, 1, 1, 0, 0);
    add("t5_abrt", 0, 8'h00, 0, 0, 0, 0, 16'h1234, 8'hCC, 0, 0, 0, 1);
    add("t5_j00",  1, 8'h00, 0, 0, 0, 0, 16'h1234, 8'hCC, 0, 0, 0, 1);
    add("t5_jAA",  1, 8'hAA, 0, 0, 0, 0, 16'h1234, 8'hCC, 0, 0, 0, 1);
    add("t5_irxe", 0, 8'h00, 1, 0, 0, 0, 16'h1234, 8'hCC, 0, 0, 0, 1);
    add("t5_idle", 0, 8'h00, 0, 0, 0, 0, 16'h1234, 8'hCC, 0, 0, 0, 1);
    add("t5_sync", 1, 8'h55, 0, 0, 0, 0, 16'h1234, 8'hCC, 0, 0, 0, 1);
    add("t5_clr",  0, 8'h00, 0, 0, 0, 0, 16'h1234, 8'hCC, 1, 1, 0, 0);
    add("t5_rxe2", 0, 8'h00, 1, 0, 0, 0, 16'h1234, 8'hCC, 1, 1, 0, 0);
    add("t5_end",  0, 8'h00, 0, 0, 0, 0, 16'h1234, 8'hCC, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].stb, vecs[i].dat, vecs[i].rxe, vecs[i].gnt);
      chk(vecs[i].name, {2'b0, outs()}, {2'b0, vecs[i].exp});
    end

    // test 3: LEN=0 means 256 writes at 0010..010F
    base = we_cnt;
    drive(1, 8'h55, 0, 1); drive(1, 8'h00, 0, 1);
    drive(1, 8'h10, 0, 1); drive(1, 8'h00, 0, 1);
    for (int k = 0; k < 256; k++) begin
      drive(1, 8'(k), 0, 1);
      drive(0, 8'h00, 0, 1);
      ea = 16'h0010 + 16'(k);
      if (k == 0 || k == 255 || bus.mem_we !== 1'b1 || bus.mem_addr !== ea)
        chk("t3_write", {7'b0, bus.mem_we, bus.mem_addr, bus.mem_wdat},
            {7'b0, 1'b1, ea, 8'(k)});
      if (k < 255 && bus.done !== 1'b0) chk("t3_early_done", {31'b0, bus.done}, 32'h0);
    end
    drive(0, 8'h00, 0, 1);
    chk("t3_done", {bus.done, bus.cpu_hold, bus.busy, bus.err, bus.mem_addr}, {4'b1000, 16'h0110});
    drive(0, 8'h00, 0, 1);
    chk("t3_done_pulse", {31'b0, bus.done}, 32'h0);
    chk("t3_write_count", we_cnt - base, 256);

    // simultaneous grant and byte in WRITE: write happens, then overrun
    base = we_cnt;
    drive(1, 8'h55, 0, 1); drive(1, 8'h40, 0, 1); drive(1, 8'h00, 0, 1);
    drive(1, 8'h02, 0, 1); drive(1, 8'h11, 0, 1);
    drive(1, 8'h22, 0, 1);
    chk("sim_write", {bus.mem_we, bus.mem_addr, bus.mem_wdat}, {1'b1, 16'h4000, 8'h11});
    drive(0, 8'h00, 0, 1);
    chk("sim_abort", {bus.mem_req, bus.cpu_hold, bus.busy, bus.done, bus.err}, 5'b00001);
    drive(0, 8'h00, 0, 1);
    chk("sim_write_count", we_cnt - base, 1);

    // asynchronous reset in WRITE drops mem_req before the next edge
    drive(1, 8'h55, 0, 0); drive(1, 8'h12, 0, 0); drive(1, 8'h34, 0, 0);
    drive(1, 8'h01, 0, 0); drive(1, 8'hAA, 0, 0);
    drive(0, 8'h00, 0, 0);
    chk("ar_req_before", {bus.mem_req, bus.mem_addr, bus.mem_wdat}, {1'b1, 16'h1234, 8'hAA});
    #1 reset = 1'b1;
    #1 chk("ar_async", {2'b0, outs()}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 8'h00, 0, 1);
    chk("ar_after", {2'b0, outs()}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
